// File: rtl/wb_uart_tx.sv
// Wishbone-slave 8N1 UART transmitter with a TX FIFO, programmable baud divisor
// and a level interrupt raised when the FIFO has drained and the line is idle.
//
// state   | meaning
// --------+---------------------------------------------
// S_IDLE  | line high, baud counter cleared, waits for FIFO data
// S_START | start bit (tx=0) for one bit time
// S_DATA  | eight data bits, LSB first
// S_STOP  | stop bit (tx=1); chains straight into S_START if FIFO has data
module wb_uart_tx #(
    parameter int FIFO_DEPTH  = 16,
    parameter int DEFAULT_DIV = 868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        tx,
    output logic        tx_irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state_q, state_d;
    logic            ack_q, ack_d;
    logic [31:0]     dat_q, dat_d;
    logic [15:0]     div_q, div_d;
    logic            irq_en_q, irq_en_d;
    logic            ovr_q, ovr_d;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [15:0]     baud_q, baud_d;
    logic [15:0]     div_lat_q, div_lat_d;

    logic            acc, wr_en, push, pop, empty, full, busy, bit_tick;
    logic [1:0]      reg_sel;
    logic [15:0]     div_eff;
    logic [31:0]     rd_data;
    logic            unused_bits;

    assign unused_bits = ^{wb_adr_i[1:0], wb_sel_i[3:2], wb_dat_i[31:16]};

    assign acc      = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr_en    = acc & wb_we_i;
    assign reg_sel  = wb_adr_i[3:2];
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(FIFO_DEPTH));
    assign busy     = (state_q != S_IDLE);
    assign push     = wr_en & (reg_sel == 2'd0) & wb_sel_i[0] & ~full;
    assign div_eff  = (div_q == 16'd0) ? 16'd1 : div_q;
    // div_lat_q holds the divisor of the bit in flight; it only reloads at bit boundaries
    assign bit_tick = (baud_q == div_lat_q - 16'd1);

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign tx_irq   = irq_en_q & empty & ~busy;

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            2'd1:    rd_data = {27'b0, ovr_q, irq_en_q, busy, full, empty};
            2'd2:    rd_data = {16'b0, div_q};
            default: rd_data = '0;
        endcase
    end

    always_comb begin
        ack_d    = acc;
        dat_d    = (acc && !wb_we_i) ? rd_data : 32'd0;
        irq_en_d = irq_en_q;
        ovr_d    = ovr_q;
        div_d    = div_q;
        if (wr_en) begin
            case (reg_sel)
                2'd0: if (wb_sel_i[0] && full) ovr_d = 1'b1;
                2'd1: if (wb_sel_i[0]) begin
                    irq_en_d = wb_dat_i[3];
                    if (wb_dat_i[4]) ovr_d = 1'b0;
                end
                2'd2: begin
                    if (wb_sel_i[0]) div_d[7:0]  = wb_dat_i[7:0];
                    if (wb_sel_i[1]) div_d[15:8] = wb_dat_i[15:8];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        pop       = 1'b0;
        tx        = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    state_d = S_START;
                end
            end
            S_START: begin
                tx = 1'b0;
                if (bit_tick) begin
                    bit_idx_d = 3'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                tx = shift_q[0];
                if (bit_tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                    else bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            S_STOP: begin
                if (bit_tick) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (pop && !push) cnt_d = cnt_q - CW'(1);

        baud_d    = baud_q + 16'd1;
        div_lat_d = div_lat_q;
        if (!busy || bit_tick) begin
            baud_d    = 16'd0;
            div_lat_d = div_eff;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wb_dat_i[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            div_q     <= 16'(DEFAULT_DIV);
            irq_en_q  <= 1'b0;
            ovr_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            shift_q   <= '0;
            bit_idx_q <= '0;
            baud_q    <= '0;
            div_lat_q <= 16'(DEFAULT_DIV);
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            div_q     <= div_d;
            irq_en_q  <= irq_en_d;
            ovr_q     <= ovr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            baud_q    <= baud_d;
            div_lat_q <= div_lat_d;
        end
    end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Bench for wb_uart_tx: a frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized bus traffic.
module tb_wb_uart_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  adr = '0, sel = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic        ack, tx, tx_irq;

    int vectors = 0;
    int miscompares = 0;

    wb_uart_tx #(.FIFO_DEPTH(16), .DEFAULT_DIV(868)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_i),
        .wb_dat_o(dat_o), .wb_ack_o(ack),
        .tx(tx), .tx_irq(tx_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the line is described as a frame of 10*d cycles indexed by m_k.
    logic [7:0]  mq[$];
    bit          m_act;
    int          m_k, m_d;
    logic [7:0]  m_b;
    logic [15:0] m_div;
    bit          m_irq_en, m_ovr, m_ack;
    logic [31:0] m_dat;

    task automatic model_reset();
        mq.delete();
        m_act = 0; m_k = 0; m_d = 1; m_b = '0;
        m_div = 16'd868; m_irq_en = 0; m_ovr = 0; m_ack = 0; m_dat = '0;
    endtask

    function automatic logic exp_tx();
        if (!m_act) return 1'b1;
        if (m_k < m_d) return 1'b0;
        if (m_k < 9 * m_d) return m_b[(m_k - m_d) / m_d];
        return 1'b1;
    endfunction

    task automatic model_step();
        int          pre;
        int          deff;
        bit          acc;
        logic [31:0] rd;
        pre  = mq.size();
        acc  = cyc && stb && !m_ack;
        deff = (m_div == 16'd0) ? 1 : int'(m_div);
        rd   = '0;
        if (adr[3:2] == 2'd1) rd = {27'b0, m_ovr, m_irq_en, m_act, pre == 16, pre == 0};
        if (adr[3:2] == 2'd2) rd = {16'b0, m_div};
        if (m_act) begin
            if (m_k == 10 * m_d - 1) begin
                m_k = 0;
                if (pre > 0) begin
                    m_b = mq.pop_front();
                    m_d = deff;
                end else begin
                    m_act = 0;
                end
            end else begin
                m_k++;
            end
        end else if (pre > 0) begin
            m_b = mq.pop_front();
            m_act = 1; m_k = 0; m_d = deff;
        end
        if (acc && we) begin
            case (adr[3:2])
                2'd0: if (sel[0]) begin
                    if (pre < 16) mq.push_back(dat_i[7:0]);
                    else m_ovr = 1;
                end
                2'd1: if (sel[0]) begin
                    m_irq_en = dat_i[3];
                    if (dat_i[4]) m_ovr = 0;
                end
                2'd2: begin
                    if (sel[0]) m_div[7:0]  = dat_i[7:0];
                    if (sel[1]) m_div[15:8] = dat_i[15:8];
                end
                default: ;
            endcase
        end
        m_ack = acc;
        m_dat = (acc && !we) ? rd : 32'd0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
            #1;
            check("tx", tx, exp_tx());
            check("ack", ack, m_ack);
            check("irq", tx_irq, m_irq_en && mq.size() == 0 && !m_act);
            if (m_ack) check("rdata", dat_o, m_dat);
        end
    end

    task automatic bus(input bit w, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rdata);
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; dat_i = d; sel = s;
        @(negedge clk);
        rdata = dat_o;
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus(1'b1, a, d, 4'hF, dummy);
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] r);
        bus(1'b0, a, 32'd0, 4'hF, r);
    endtask

    task automatic wait_tx_low(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (tx == 1'b0) break;
        end
        check("tx_start_seen", tx, 0);
    endtask

    // Samples tx once per bit starting at the current negedge.
    task automatic capture(input int d, input int n, output logic [31:0] bits);
        bits = '0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) repeat (d) @(negedge clk);
            bits[i] = tx;
        end
    endtask

    task automatic wait_drain(input int max);
        logic [31:0] r;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!m_act && mq.size() == 0) break;
        end
        rd(4'h4, r);
        check("drain_status", {29'b0, r[2:0]}, 32'h1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, bits;
        logic [31:0] r2;
        int          op;

        repeat (3) @(negedge clk);
        rst_n = 1;

        // 1: reset state and ack timing
        check("tx_reset", tx, 1);
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 4'h4; sel = 4'hF;
        check("ack_before", ack, 0);
        @(negedge clk);
        check("ack_after", ack, 1);
        check("status_reset", dat_o, 32'h01);
        cyc = 0; stb = 0;
        @(negedge clk);
        check("ack_single", ack, 0);
        rd(4'h8, r);
        check("div_reset", r, 868);
        rd(4'h0, r);
        check("txdata_read", r, 0);

        // 2: one frame at div 4
        wr(4'h8, 4);
        wr(4'h0, 8'hA5);
        wait_tx_low(10);
        capture(4, 10, bits);
        check("frame_a5", bits, 32'b1101001010);
        wait_drain(200);

        // 3: back-to-back frames at div 2
        wr(4'h8, 2);
        wr(4'h0, 8'h00);
        wait_tx_low(10);
        fork
            capture(2, 20, bits);
            wr(4'h0, 8'hFF);
        join
        check("frames_00_ff", bits, 32'hFFA00);
        wait_drain(200);

        // 4: fill FIFO and overrun at div 1000
        wr(4'h8, 1000);
        for (int i = 0; i < 17; i++) wr(4'h0, 32'(i));
        rd(4'h4, r);
        check("status_full", r, 32'h06);
        wr(4'h0, 8'h55);
        rd(4'h4, r);
        check("status_overrun", r, 32'h16);
        wr(4'h4, 32'h10);
        rd(4'h4, r);
        check("status_w1c", r, 32'h06);

        // 6: async reset in data bit 3 of the first (0x00) byte
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            if (m_act && m_k == 4500) break;
        end
        check("tx_mid_frame", tx, 0);
        rst_n = 0;
        #1;
        check("tx_async_reset", tx, 1);
        repeat (2) @(negedge clk);
        rst_n = 1;
        rd(4'h4, r);
        check("status_after_reset", r, 32'h01);
        rd(4'h8, r);
        check("div_after_reset", r, 868);
        wr(4'h8, 0);
        wr(4'h0, 8'h00);
        wait_tx_low(10);
        capture(1, 11, bits);
        check("frame_div0", bits, 32'h600);
        wait_drain(100);

        // 5: interrupt
        wr(4'h4, 32'h08);
        @(negedge clk);
        check("irq_enabled", tx_irq, 1);
        wr(4'h0, 8'h3C);
        check("irq_after_push", tx_irq, 0);
        wait_drain(100);
        check("irq_after_drain", tx_irq, 1);
        wr(4'h4, 32'h00);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1, 2, 3, 4:
                    bus(1'b1, 4'h0, $urandom, 4'($urandom_range(0, 15)), r2);
                5: rd(4'($urandom_range(0, 15)), r2);
                6: bus(1'b1, 4'h4, $urandom & 32'h18, 4'($urandom_range(0, 15)), r2);
                7: if (!m_act && mq.size() == 0)
                       bus(1'b1, 4'h8, $urandom_range(0, 6), 4'($urandom_range(0, 15)), r2);
                   else rd(4'h8, r2);
                8: bus(1'b1, 4'hC | 4'($urandom_range(0, 3)), $urandom, 4'hF, r2);
                default: repeat ($urandom_range(0, 30)) @(negedge clk);
            endcase
        end
        wait_drain(20000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
